// File: rtl/div_pkg.sv
// div_pkg: opcode encodings and FSM state type shared by the divide unit and its bench.
`timescale 1ns/1ps
package div_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_DIV  = 4'd0;  // signed quotient
  localparam logic [OPC_W-1:0] OP_DIVU = 4'd1;  // unsigned quotient
  localparam logic [OPC_W-1:0] OP_REM  = 4'd2;  // signed remainder
  localparam logic [OPC_W-1:0] OP_REMU = 4'd3;  // unsigned remainder

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem     - partial remainder (DATA_WIDTH+1 bits)
//   quo     - quotient/dividend shift register
//   divisor - divisor magnitude
//   nextRem / nextQuo - values after one shift-and-trial-subtract step
`timescale 1ns/1ps
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   nextRem,
  output logic [DATA_WIDTH-1:0] nextQuo
);

  logic                borrow;
  logic [DATA_WIDTH:0] trial;

  // Subtract one bit wider than the shifted remainder so the borrow is the top bit.
  always_comb begin
    {borrow, trial} = {rem, quo[DATA_WIDTH-1]} - (DATA_WIDTH+2)'(divisor);
    if (borrow) begin
      nextRem = {rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]};
      nextQuo = quo << 1;
    end else begin
      nextRem = trial;
      nextQuo = (quo << 1) | DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/div_operation.sv
// div_operation: multi-cycle DIV/DIVU/REM/REMU unit, fixed latency.
//   clk, rst_n          - clock, async active-low reset
//   start, Operation    - request and opcode (sampled in IDLE only)
//   SrcA, SrcB          - dividend, divisor (sampled with start)
//   busy                - iterating; pipeline stalls on it
//   done                - one-cycle pulse when Rd is valid
//   Rd                  - result, held until the next accepted start
`timescale 1ns/1ps
module div_operation
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    Rd
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  div_state_t               state;
  logic [OPCODE_LENGTH-1:0] opReg;
  logic                     signA;
  logic                     signB;
  logic [DATA_WIDTH-1:0]    divisor;
  logic [DATA_WIDTH:0]      rem;
  logic [DATA_WIDTH-1:0]    quo;
  logic [CNT_W-1:0]         cnt;

  logic [DATA_WIDTH:0]   stepRem;
  logic [DATA_WIDTH-1:0] stepQuo;

  logic                  isDiv, isDivu, isRem, isRemu, isSigned, validOp;
  logic                  negA, negB, divZero, overflow;
  logic [DATA_WIDTH-1:0] magA, magB;
  logic                  fixIsRem;
  logic [DATA_WIDTH-1:0] quoFix, remFix;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .nextRem (stepRem),
    .nextQuo (stepQuo)
  );

  // Decode of the incoming request: operand magnitudes and special cases.
  always_comb begin
    isDiv    = (Operation == OPCODE_LENGTH'(OP_DIV));
    isDivu   = (Operation == OPCODE_LENGTH'(OP_DIVU));
    isRem    = (Operation == OPCODE_LENGTH'(OP_REM));
    isRemu   = (Operation == OPCODE_LENGTH'(OP_REMU));
    isSigned = isDiv | isRem;
    validOp  = isDiv | isDivu | isRem | isRemu;
    negA     = isSigned & SrcA[DATA_WIDTH-1];
    negB     = isSigned & SrcB[DATA_WIDTH-1];
    // Negating the most negative value yields its own bit pattern, the correct magnitude.
    magA     = negA ? -SrcA : SrcA;
    magB     = negB ? -SrcB : SrcB;
    divZero  = (SrcB == '0);
    overflow = isSigned && (SrcA == MOST_NEG) && (SrcB == '1);
  end

  // Sign correction and result select for the FIX state.
  always_comb begin
    fixIsRem = (opReg == OPCODE_LENGTH'(OP_REM)) || (opReg == OPCODE_LENGTH'(OP_REMU));
    quoFix   = (signA ^ signB) ? -quo : quo;
    remFix   = signA ? -rem[DATA_WIDTH-1:0] : rem[DATA_WIDTH-1:0];
  end

  // Control FSM with registered busy/done/Rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opReg   <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Rd      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opReg   <= Operation;
            signA   <= negA;
            signB   <= negB;
            divisor <= magB;
            quo     <= magA;
            rem     <= '0;
            cnt     <= '0;
            if (!validOp) begin
              Rd    <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else if (divZero) begin
              Rd    <= (isRem | isRemu) ? SrcA : '1;
              done  <= 1'b1;
              state <= DONE;
            end else if (overflow) begin
              Rd    <= isDiv ? SrcA : '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= stepRem;
          quo <= stepQuo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          Rd    <= fixIsRem ? remFix : quoFix;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_operation.sv
// tb_div_operation: directed checks of div_operation at DATA_WIDTH 8, 32 and 1.
`timescale 1ns/1ps
module tb_div_operation;
  import div_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, busy8, done8;
  logic [3:0] op8;
  logic [7:0] a8, b8, rd8;

  logic        start32, busy32, done32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, rd32;

  logic       start1, busy1, done1;
  logic [3:0] op1;
  logic [0:0] a1, b1, rd1;

  int cmpCount = 0;
  int errCount = 0;

  div_operation #(.DATA_WIDTH(8), .OPCODE_LENGTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .Operation(op8), .SrcA(a8), .SrcB(b8),
    .busy(busy8), .done(done8), .Rd(rd8));

  div_operation #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .Operation(op32), .SrcA(a32), .SrcB(b32),
    .busy(busy32), .done(done32), .Rd(rd32));

  div_operation #(.DATA_WIDTH(1), .OPCODE_LENGTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .Operation(op1), .SrcA(a1), .SrcB(b1),
    .busy(busy1), .done(done1), .Rd(rd1));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {busy, done, Rd zero-extended} of one instance: 0 = 8-bit, 1 = 32-bit, 2 = 1-bit.
  function automatic logic [33:0] probe(input int inst);
    case (inst)
      0:       return {busy8, done8, 24'h0, rd8};
      1:       return {busy32, done32, rd32};
      default: return {busy1, done1, 31'h0, rd1};
    endcase
  endfunction

  task automatic drive(input int inst, input logic s, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    case (inst)
      0: begin start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
      1: begin start32 = s; op32 = op; a32 = a; b32 = b; end
      default: begin start1 = s; op1 = op; a1 = a[0:0]; b1 = b[0:0]; end
    endcase
  endtask

  // Present a request for one edge (E0), then scramble operands to show they are not re-read.
  task automatic issue(input int inst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(inst, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(inst, 1'b0, op, ~a, ~b);
  endtask

  task automatic runOp(input string tag, input int inst, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] expRd,
                       input int expLat, input int pokeAt);
    logic [33:0] p;
    logic [31:0] rdBefore;
    int          lat;
    bit          sawBusy;
    bit          rdMoved;
    p        = probe(inst);
    rdBefore = p[31:0];
    issue(inst, op, a, b);
    lat     = 1;
    p       = probe(inst);
    sawBusy = p[33];
    rdMoved = 1'b0;
    while (p[32] !== 1'b1 && lat < 200) begin
      if (lat == pokeAt) drive(inst, 1'b1, OP_DIVU, 32'h64, 32'h07);
      else               drive(inst, 1'b0, OP_DIVU, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      lat++;
      p = probe(inst);
      if (p[33]) sawBusy = 1'b1;
      if (p[32] !== 1'b1 && p[31:0] !== rdBefore) rdMoved = 1'b1;
    end
    drive(inst, 1'b0, OP_DIVU, 32'h0, 32'h0);
    checkVal({tag, ".rd"}, p[31:0], expRd);
    checkVal({tag, ".latency"}, lat, expLat);
    checkVal({tag, ".busyAtDone"}, 32'(p[33]), 0);
    checkVal({tag, ".sawBusy"}, 32'(sawBusy), 32'(expLat > 1));
    checkVal({tag, ".rdStable"}, 32'(rdMoved), 0);
    @(posedge clk);
    #1;
    p = probe(inst);
    checkVal({tag, ".donePulse"}, 32'(p[32]), 0);
    checkVal({tag, ".rdHeld"}, p[31:0], expRd);
  endtask

  initial begin
    logic [33:0] p;
    int dones;
    rst_n = 1'b0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      p = probe(i);
      checkVal($sformatf("reset%0d.busy", i), 32'(p[33]), 0);
      checkVal($sformatf("reset%0d.done", i), 32'(p[32]), 0);
      checkVal($sformatf("reset%0d.rd", i), p[31:0], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit normal operations
    runOp("divu_64_07", 0, OP_DIVU, 32'h64, 32'h07, 32'h0E, 10, -1);
    runOp("remu_64_07", 0, OP_REMU, 32'h64, 32'h07, 32'h02, 10, -1);
    runOp("div_f9_02",  0, OP_DIV,  32'hF9, 32'h02, 32'hFD, 10, -1);
    runOp("rem_f9_02",  0, OP_REM,  32'hF9, 32'h02, 32'hFF, 10, -1);
    runOp("rem_07_fe",  0, OP_REM,  32'h07, 32'hFE, 32'h01, 10, -1);
    runOp("div_9c_f9",  0, OP_DIV,  32'h9C, 32'hF9, 32'h0E, 10, -1);
    runOp("rem_9c_f9",  0, OP_REM,  32'h9C, 32'hF9, 32'hFE, 10, -1);
    runOp("divu_ff_01", 0, OP_DIVU, 32'hFF, 32'h01, 32'hFF, 10, -1);

    // 8-bit special cases
    runOp("divu_2a_00", 0, OP_DIVU, 32'h2A, 32'h00, 32'hFF, 1, -1);
    runOp("remu_2a_00", 0, OP_REMU, 32'h2A, 32'h00, 32'h2A, 1, -1);
    runOp("div_80_ff",  0, OP_DIV,  32'h80, 32'hFF, 32'h80, 1, -1);
    runOp("rem_80_ff",  0, OP_REM,  32'h80, 32'hFF, 32'h00, 1, -1);
    runOp("bad_op8",    0, 4'h9,    32'h55, 32'h03, 32'h00, 1, -1);

    // Reset in the middle of an 8-bit DIVU (Rd currently holds a non-zero value from before)
    runOp("divu_pre",   0, OP_DIVU, 32'h30, 32'h04, 32'h0C, 10, -1);
    issue(0, OP_DIVU, 32'h64, 32'h07);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    p = probe(0);
    checkVal("abort.busy", 32'(p[33]), 0);
    checkVal("abort.done", 32'(p[32]), 0);
    checkVal("abort.rd", p[31:0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done8) dones++;
    end
    checkVal("abort.noDone", dones, 0);
    checkVal("abort.rdStillZero", 32'(rd8), 0);
    runOp("divu_09_03", 0, OP_DIVU, 32'h09, 32'h03, 32'h03, 10, -1);

    // 32-bit, with a start pulse during busy that must be ignored
    runOp("divu32_f_5", 1, OP_DIVU, 32'h0000000F, 32'h00000005, 32'h00000003, 34, 5);
    runOp("div32_neg",  1, OP_DIV,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 34, -1);
    runOp("rem32_ovf",  1, OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, -1);

    // 1-bit width
    runOp("divu1_1_1", 2, OP_DIVU, 32'h1, 32'h1, 32'h1, 3, -1);
    runOp("remu1_1_1", 2, OP_REMU, 32'h1, 32'h1, 32'h0, 3, -1);
    runOp("bad_op1",   2, 4'hF,    32'h1, 32'h1, 32'h0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
